// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU memory port: funct3 widths, memory op codes, FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] OP_WORD = 2'b00;
    localparam logic [1:0] OP_HALF = 2'b01;
    localparam logic [1:0] OP_BYTE = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    // funct3[1] marks a word; funct3[0] a half; otherwise a byte (unsigned bit ignored).
    function automatic logic [1:0] f3_to_op(input logic [2:0] f3);
        if (f3[1])      return OP_WORD;
        else if (f3[0]) return OP_HALF;
        return OP_BYTE;
    endfunction

    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        if (f3[1])      return 3'd4;
        else if (f3[0]) return 3'd2;
        return 3'd1;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extension: sign/zero extend bytes and halves, words pass through.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] data,
    output logic [31:0] ext
);

    always_comb begin
        ext = data;
        case (funct3)
            F3_B:    ext = {{24{data[7]}}, data[7:0]};
            F3_H:    ext = {{16{data[15]}}, data[15:0]};
            F3_BU:   ext = {24'b0, data[7:0]};
            F3_HU:   ext = {16'b0, data[15:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// LSU data-memory port: range/alignment checks, single-op access or byte-serial split.
// Define LSU_MISALIGN_SPLIT_EN to service misaligned accesses as byte sequences instead of faulting.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       rd_data,
    output logic              misalign_err,
    output logic              access_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        mem_op,
    input  logic [31:0]       mem_rdata
);

    state_t            state, state_nx;
    logic              store_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q, ext_data;
    logic              acc_err_q, mis_err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]        cnt_q;
`endif

    logic [1:0]  req_op;
    logic [32:0] last_byte;
    logic        range_bad, misal, accept;

    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    assign req_op    = f3_to_op(req_funct3);
    assign last_byte = {1'b0, req_addr} + {30'b0, f3_size(req_funct3)} - 33'd1;
    assign range_bad = |last_byte[32:ADDR_W];
    assign misal     = ((req_op == OP_HALF) && req_addr[0]) ||
                       ((req_op == OP_WORD) && (req_addr[1:0] != 2'b00));
    assign accept    = req_valid && (state == IDLE);

    lsu_load_ext u_ext (
        .funct3 (f3_q),
        .data   (rdata_q),
        .ext    (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            store_q   <= 1'b0;
            f3_q      <= 3'b0;
            addr_q    <= '0;
            wdata_q   <= 32'b0;
            rdata_q   <= 32'b0;
            acc_err_q <= 1'b0;
            mis_err_q <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            cnt_q     <= 2'b0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                store_q   <= req_store;
                f3_q      <= req_funct3;
                addr_q    <= req_addr[ADDR_W-1:0];
                wdata_q   <= req_wdata;
                rdata_q   <= 32'b0;
                acc_err_q <= range_bad;
`ifdef LSU_MISALIGN_SPLIT_EN
                mis_err_q <= 1'b0;
                cnt_q     <= 2'b0;
`else
                mis_err_q <= misal && !range_bad;
`endif
            end
            if (state == ACCESS && !store_q)
                rdata_q <= mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state == SPLIT) begin
                if (!store_q)
                    rdata_q[{cnt_q, 3'b000} +: 8] <= mem_rdata[7:0];
                cnt_q <= cnt_q + 2'd1;
            end
`endif
        end
    end

    always_comb begin
        state_nx     = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        rd_data      = 32'b0;
        misalign_err = 1'b0;
        access_err   = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        mem_addr     = '0;
        mem_wdata    = 32'b0;
        mem_op       = OP_WORD;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (range_bad)  state_nx = RESP;
                    else if (misal) state_nx = SPLIT;
                    else            state_nx = ACCESS;
`else
                    if (range_bad || misal) state_nx = RESP;
                    else                    state_nx = ACCESS;
`endif
                end
            end
            ACCESS: begin
                MemRead   = !store_q;
                MemWrite  = store_q;
                mem_op    = f3_to_op(f3_q);
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                state_nx  = RESP;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            SPLIT: begin
                MemRead   = !store_q;
                MemWrite  = store_q;
                mem_op    = OP_BYTE;
                mem_addr  = addr_q + ADDR_W'(cnt_q);
                mem_wdata = {24'b0, wdata_q[{cnt_q, 3'b000} +: 8]};
                if (cnt_q == 2'(f3_size(f3_q) - 3'd1))
                    state_nx = RESP;
            end
`endif
            RESP: begin
                resp_valid   = 1'b1;
                access_err   = acc_err_q;
                misalign_err = mis_err_q;
                rd_data      = (store_q || acc_err_q || mis_err_q) ? 32'b0 : ext_data;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
